// File: rtl/rc_bridge_pkg.sv
// Shared types for the RC transfer bridge: request record, opcodes, FSM states, error bits.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package rc_bridge_pkg;

  localparam int          DEF_FIFO_DEPTH   = 4;
  localparam int          DEF_RSP_TIMEOUT  = 24;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Opcode encoding shared by the request and response channels
  typedef enum logic [1:0] {
    NONE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } rc_opcode_t;

  // One queued or in-flight RC request
  typedef struct packed {
    rc_opcode_t  opcode;
    logic [31:0] address;
    logic [31:0] data;
  } rc_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } bridge_state_t;

  // Bit positions inside the sticky err_status vector
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_PROTO    = 1;
  localparam int ERR_STRAY    = 2;
  localparam int ERR_TIMEOUT  = 3;
  localparam int ERR_W        = 4;

  // Builds a request record; reads always carry zero data
  function automatic rc_req_t mk_req(input rc_opcode_t op,
                                     input logic [31:0] addr,
                                     input logic [31:0] dat);
    rc_req_t r;
    r.opcode  = op;
    r.address = addr;
    r.data    = (op == WR) ? dat : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/rc_req_fifo.sv
// Synchronous request FIFO of rc_req_t records, DEPTH entries (power of 2).
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module rc_req_fifo
  import rc_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  rc_req_t push_dat,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output rc_req_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rc_req_t     mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the low bits wrap modulo DEPTH naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/rc_transfer_bridge.sv
// Bridges handler transfer pulses to the RC valid/ready channel, one request outstanding.
// Latency: pulse at N -> rc_req_valid at N+2; rc_rsp_valid at M -> resp pulse at M+1.
// Backpressure: 4-deep queue absorbs pulses while RC stalls; pushes into a full queue are dropped and flagged.
module rc_transfer_bridge
  import rc_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int          RSP_TIMEOUT  = DEF_RSP_TIMEOUT,
  parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_transfer_valid,
  input  logic             read_transfer_valid,
  input  logic [31:0]      address,
  input  logic [31:0]      data_out,
  output logic             write_resp_valid,
  output logic             read_resp_valid,
  output logic [31:0]      data_in,
  output logic             rc_req_valid,
  input  logic             rc_req_ready,
  output logic [1:0]       rc_req_opcode,
  output logic [31:0]      rc_req_address,
  output logic [31:0]      rc_req_data,
  input  logic             rc_rsp_valid,
  input  logic [1:0]       rc_rsp_opcode,
  input  logic [31:0]      rc_rsp_data,
  output logic             rsp_error,
  output logic [ERR_W-1:0] err_status,
  input  logic             err_clear,
  output logic             busy
);

  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  bridge_state_t    state;
  rc_req_t          req_q;
  logic [TW-1:0]    timer;

  rc_req_t          push_dat;
  rc_req_t          fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push_req;
  logic             both_pulse;
  logic             overflow;
  logic             rsp_match;
  logic             timer_done;
  logic [ERR_W-1:0] err_set;

  assign push_req   = write_transfer_valid || read_transfer_valid;
  assign both_pulse = write_transfer_valid && read_transfer_valid;
  // The FSM only drains the queue from IDLE, one entry per request
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign overflow   = push_req && fifo_full && !fifo_pop;
  assign rsp_match  = rc_rsp_valid && (rc_rsp_opcode == req_q.opcode);
  assign timer_done = (timer == TW'(RSP_TIMEOUT - 1));

  // Write wins when both pulses arrive together; the read is simply not queued
  always_comb begin
    push_dat = '0;
    if (write_transfer_valid)
      push_dat = mk_req(WR, address, data_out);
    else if (read_transfer_valid)
      push_dat = mk_req(RD, address, 32'd0);
  end

  rc_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // Error events raised this cycle; a matching response beats a same-cycle timeout
  always_comb begin
    err_set               = '0;
    err_set[ERR_OVERFLOW] = overflow;
    err_set[ERR_PROTO]    = both_pulse;
    err_set[ERR_STRAY]    = rc_rsp_valid && ((state != WAIT_RSP) || !rsp_match);
    err_set[ERR_TIMEOUT]  = (state == WAIT_RSP) && !rsp_match && timer_done;
  end

  // Request FSM with registered request fields, response pulses and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      req_q            <= '0;
      timer            <= '0;
      rc_req_valid     <= 1'b0;
      write_resp_valid <= 1'b0;
      read_resp_valid  <= 1'b0;
      rsp_error        <= 1'b0;
      data_in          <= '0;
    end else begin
      write_resp_valid <= 1'b0;
      read_resp_valid  <= 1'b0;
      rsp_error        <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            req_q        <= fifo_head;
            rc_req_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (rc_req_ready) begin
            rc_req_valid <= 1'b0;
            timer        <= '0;
            state        <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_match) begin
            state <= IDLE;
            if (req_q.opcode == RD) begin
              read_resp_valid <= 1'b1;
              data_in         <= rc_rsp_data;
            end else begin
              write_resp_valid <= 1'b1;
            end
          end else if (timer_done) begin
            state     <= IDLE;
            rsp_error <= 1'b1;
            if (req_q.opcode == RD) begin
              read_resp_valid <= 1'b1;
              data_in         <= TIMEOUT_DATA;
            end else begin
              write_resp_valid <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          rc_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; an event in the clearing cycle still lands
  always_ff @(posedge clk) begin
    if (rst) err_status <= '0;
    else     err_status <= (err_status & ~{ERR_W{err_clear}}) | err_set;
  end

  assign rc_req_opcode  = req_q.opcode;
  assign rc_req_address = req_q.address;
  assign rc_req_data    = req_q.data;
  assign busy           = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_rc_transfer_bridge.sv
// Self-checking bench for rc_transfer_bridge: directed vector table, corner sequences, random run.
// Latency: checks N+2 issue, M+1 response and the timeout window.
// Backpressure: exercises RC stalls, queue overflow and reset mid-transaction.
module tb_rc_transfer_bridge;
  import rc_bridge_pkg::*;

  localparam int          RSP_TIMEOUT  = 24;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_transfer_valid, read_transfer_valid;
  logic [31:0] address, data_out;
  logic        write_resp_valid, read_resp_valid;
  logic [31:0] data_in;
  logic        rc_req_valid, rc_req_ready;
  logic [1:0]  rc_req_opcode;
  logic [31:0] rc_req_address, rc_req_data;
  logic        rc_rsp_valid;
  logic [1:0]  rc_rsp_opcode;
  logic [31:0] rc_rsp_data;
  logic        rsp_error;
  logic [3:0]  err_status;
  logic        err_clear;
  logic        busy;

  always #5 clk = ~clk;

  rc_transfer_bridge dut (
    .clk                  (clk),
    .rst                  (rst),
    .write_transfer_valid (write_transfer_valid),
    .read_transfer_valid  (read_transfer_valid),
    .address              (address),
    .data_out             (data_out),
    .write_resp_valid     (write_resp_valid),
    .read_resp_valid      (read_resp_valid),
    .data_in              (data_in),
    .rc_req_valid         (rc_req_valid),
    .rc_req_ready         (rc_req_ready),
    .rc_req_opcode        (rc_req_opcode),
    .rc_req_address       (rc_req_address),
    .rc_req_data          (rc_req_data),
    .rc_rsp_valid         (rc_rsp_valid),
    .rc_rsp_opcode        (rc_rsp_opcode),
    .rc_rsp_data          (rc_rsp_data),
    .rsp_error            (rsp_error),
    .err_status           (err_status),
    .err_clear            (err_clear),
    .busy                 (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rsp_delay;      // cycles after acceptance; 0 = RC never answers
    logic        bad_first;      // wrong-opcode response one cycle before the real one
    logic [31:0] rsp_rdata;
    logic [1:0]  exp_op;
    logic [31:0] exp_req_data;
    logic        exp_wr_resp;
    logic        exp_rd_resp;
    logic        exp_err;
    logic [31:0] exp_data_in;
    logic [3:0]  exp_err_status;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  vec_t        vecs [6];
  mreq_t       exp_q [$];
  mreq_t       m_new, m_acc;
  logic [31:0] got_addr [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    write_transfer_valid = 1'b0;
    read_transfer_valid  = 1'b0;
    address              = '0;
    data_out             = '0;
    rc_req_ready         = 1'b0;
    rc_rsp_valid         = 1'b0;
    rc_rsp_opcode        = 2'b00;
    rc_rsp_data          = '0;
    err_clear            = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, {21'd0, write_resp_valid, read_resp_valid, rsp_error,
                         rc_req_valid, busy, err_status, rc_req_opcode}, 32'd0);
    chk({tag, "_data"}, data_in | rc_req_address | rc_req_data, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit early;
    int limit;
    do_reset();
    chk_reset_state($sformatf("v%0d_rst", idx));
    write_transfer_valid = v.wr;
    read_transfer_valid  = v.rd;
    address              = v.addr;
    data_out             = v.wdata;
    tick();
    write_transfer_valid = 1'b0;
    read_transfer_valid  = 1'b0;
    address              = 32'hFFFF_FFFF;
    data_out             = 32'hFFFF_FFFF;
    chk($sformatf("v%0d_valid_n1", idx), rc_req_valid, 1'b0);
    tick();
    chk($sformatf("v%0d_valid_n2", idx), rc_req_valid, 1'b1);
    chk($sformatf("v%0d_req_op", idx), rc_req_opcode, v.exp_op);
    chk($sformatf("v%0d_req_addr", idx), rc_req_address, v.addr);
    chk($sformatf("v%0d_req_data", idx), rc_req_data, v.exp_req_data);
    rc_req_ready = 1'b1;
    tick();
    rc_req_ready = 1'b0;
    chk($sformatf("v%0d_accepted", idx), rc_req_valid, 1'b0);
    limit = (v.rsp_delay == 0) ? RSP_TIMEOUT : v.rsp_delay;
    early = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (write_resp_valid || read_resp_valid) early = 1'b1;
      rc_rsp_valid = 1'b0;
      if (v.rsp_delay != 0 && k == limit) begin
        rc_rsp_valid  = 1'b1;
        rc_rsp_opcode = v.exp_op;
        rc_rsp_data   = v.rsp_rdata;
      end else if (v.rsp_delay != 0 && v.bad_first && k == limit - 1) begin
        rc_rsp_valid  = 1'b1;
        rc_rsp_opcode = (v.exp_op == 2'b01) ? 2'b10 : 2'b01;
        rc_rsp_data   = 32'h5555_5555;
      end
      tick();
    end
    rc_rsp_valid = 1'b0;
    chk($sformatf("v%0d_no_early_pulse", idx), early, 1'b0);
    chk($sformatf("v%0d_wr_resp", idx), write_resp_valid, v.exp_wr_resp);
    chk($sformatf("v%0d_rd_resp", idx), read_resp_valid, v.exp_rd_resp);
    chk($sformatf("v%0d_rsp_error", idx), rsp_error, v.exp_err);
    chk($sformatf("v%0d_data_in", idx), data_in, v.exp_data_in);
    chk($sformatf("v%0d_err_status", idx), err_status, v.exp_err_status);
    tick();
    chk($sformatf("v%0d_pulse_end", idx), {write_resp_valid, read_resp_valid, rsp_error}, 3'b000);
    chk($sformatf("v%0d_data_held", idx), data_in, v.exp_data_in);
    chk($sformatf("v%0d_idle", idx), busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit flag;
    bit pend;
    int n;
    int n_wr;
    int outstanding;
    int rsp_at;
    int pulse_at;
    logic [1:0]  fl_op, pulse_op;
    logic [31:0] pulse_data;
    logic [1:0]  got;

    rst = 1'b1;
    clear_inputs();

    // wr rd addr wdata delay bad_first rsp_rdata | exp_op req_data wr_rsp rd_rsp err data_in err_status
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 3, 1'b0, 32'h0,
                2'b01, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h7777_7777, 2, 1'b0, 32'hCAFE_F00D,
                2'b10, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 4'b0000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_3000, 32'h0, 0, 1'b0, 32'h0,
                2'b10, 32'h0, 1'b0, 1'b1, 1'b1, TIMEOUT_DATA, 4'b1000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 1, 1'b0, 32'h0,
                2'b01, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0010};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0BAD_F00D, 4, 1'b1, 32'h0,
                2'b01, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0100};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_6000, 32'h0, 1, 1'b0, 32'h1357_9BDF,
                2'b10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF, 4'b0000};

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Overflow: six back-to-back writes while RC stalls; the sixth is lost
    do_reset();
    for (int i = 0; i < 6; i++) begin
      write_transfer_valid = 1'b1;
      address              = 32'h100 + i;
      data_out             = i;
      tick();
      if (i == 4) chk("ovf_none_after5", err_status[0], 1'b0);
    end
    write_transfer_valid = 1'b0;
    chk("ovf_set_after6", err_status, 4'b0001);
    got_addr.delete();
    pend         = 1'b0;
    n_wr         = 0;
    rc_req_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      n_wr += int'(write_resp_valid);
      rc_rsp_valid  = pend;
      rc_rsp_opcode = 2'b01;
      pend          = 1'b0;
      if (rc_req_valid && rc_req_ready) begin
        got_addr.push_back(rc_req_address);
        pend = 1'b1;
      end
      tick();
    end
    rc_rsp_valid = 1'b0;
    chk("ovf_req_count", got_addr.size(), 5);
    for (int i = 0; i < got_addr.size(); i++)
      chk($sformatf("ovf_req_order%0d", i), got_addr[i], 32'h100 + i);
    chk("ovf_wr_resp_count", n_wr, 5);
    chk("ovf_idle", busy, 1'b0);

    // Clearing: an event in the clearing cycle survives, then a plain clear empties it
    err_clear            = 1'b1;
    write_transfer_valid = 1'b1;
    read_transfer_valid  = 1'b1;
    tick();
    write_transfer_valid = 1'b0;
    read_transfer_valid  = 1'b0;
    err_clear            = 1'b0;
    chk("clr_set_wins", err_status, 4'b0010);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_done", err_status, 4'b0000);

    // Timeout window, then a late response is stray and silent
    do_reset();
    rc_req_ready        = 1'b1;
    read_transfer_valid = 1'b1;
    address             = 32'h7000;
    tick();
    read_transfer_valid = 1'b0;
    n = 0;
    while (!read_resp_valid && n < 60) begin
      tick();
      n++;
    end
    chk("to_latency", n, 26);
    chk("to_rsp_error", rsp_error, 1'b1);
    chk("to_data_in", data_in, TIMEOUT_DATA);
    rc_rsp_valid  = 1'b1;
    rc_rsp_opcode = 2'b10;
    rc_rsp_data   = 32'h1111_1111;
    tick();
    rc_rsp_valid = 1'b0;
    chk("late_err", err_status, 4'b1100);
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (write_resp_valid || read_resp_valid) flag = 1'b1;
      tick();
    end
    chk("late_no_pulse", flag, 1'b0);
    chk("late_data_held", data_in, TIMEOUT_DATA);

    // Reset while waiting with two requests queued behind the in-flight one
    do_reset();
    rc_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_transfer_valid = 1'b1;
      address             = 32'h8000 + i;
      tick();
    end
    read_transfer_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("mid_rst");
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rc_req_valid || busy) flag = 1'b1;
      tick();
    end
    chk("mid_no_req", flag, 1'b0);
    rc_rsp_valid  = 1'b1;
    rc_rsp_opcode = 2'b10;
    tick();
    rc_rsp_valid = 1'b0;
    chk("mid_late_stray", err_status, 4'b0100);
    chk("mid_late_no_pulse", {write_resp_valid, read_resp_valid}, 2'b00);

    // Random traffic against an in-order queue model; at most four open requests
    do_reset();
    exp_q.delete();
    outstanding = 0;
    rsp_at      = -1;
    pulse_at    = -1;
    fl_op       = 2'b00;
    pulse_op    = 2'b00;
    pulse_data  = '0;
    for (int k = 0; k < 3000; k++) begin
      got = {write_resp_valid, read_resp_valid};
      if (cyc == pulse_at) begin
        chk("rnd_pulse", got, (pulse_op == 2'b01) ? 2'b10 : 2'b01);
        chk("rnd_rsp_error", rsp_error, 1'b0);
        if (pulse_op == 2'b10) chk("rnd_data_in", data_in, pulse_data);
        outstanding--;
      end else if (got != 2'b00) begin
        chk("rnd_spurious_pulse", got, 2'b00);
      end

      rc_req_ready = ($urandom_range(0, 2) != 0);
      rc_rsp_valid = 1'b0;
      if (rc_req_valid && rc_req_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_req", 1, 0);
        end else begin
          m_acc = exp_q.pop_front();
          chk("rnd_req_op", rc_req_opcode, m_acc.op);
          chk("rnd_req_addr", rc_req_address, m_acc.addr);
          chk("rnd_req_data", rc_req_data, m_acc.data);
          fl_op  = m_acc.op;
          rsp_at = cyc + $urandom_range(1, 8);
        end
      end
      if (cyc == rsp_at) begin
        rc_rsp_valid  = 1'b1;
        rc_rsp_opcode = fl_op;
        rc_rsp_data   = $urandom();
        pulse_at      = cyc + 1;
        pulse_op      = fl_op;
        pulse_data    = rc_rsp_data;
      end

      write_transfer_valid = 1'b0;
      read_transfer_valid  = 1'b0;
      address              = $urandom();
      data_out             = $urandom();
      if (k < 2800 && outstanding < 4 && $urandom_range(0, 2) == 0) begin
        m_new.addr = address;
        if ($urandom_range(0, 1) == 1) begin
          write_transfer_valid = 1'b1;
          m_new.op   = 2'b01;
          m_new.data = data_out;
        end else begin
          read_transfer_valid = 1'b1;
          m_new.op   = 2'b10;
          m_new.data = 32'd0;
        end
        exp_q.push_back(m_new);
        outstanding++;
      end
      tick();
    end
    clear_inputs();
    chk("rnd_all_issued", exp_q.size(), 0);
    chk("rnd_all_answered", outstanding, 0);
    chk("rnd_no_errors", err_status, 4'b0000);
    chk("rnd_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
